// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Port selection for round-robin lives here so the arbiter and its users agree on it.
package mem_arb_pkg;

  localparam int DEFAULT_LATENCY    = 4;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH         = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_e;

  // On a tie the port that was not served last wins.
  function automatic arb_port_e pickPort(input logic ifReq,
                                         input logic dmReq,
                                         input arb_port_e lastGrant);
    arb_port_e sel;
    sel = PORT_FETCH;
    if (ifReq && dmReq) begin
      sel = (lastGrant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (dmReq) begin
      sel = PORT_DATA;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency down-counter: loads LATENCY-1 on grant, counts to zero and holds there.
module mem_lat_counter #(
  parameter int LATENCY = 4,
  localparam int CW = $clog2(LATENCY) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(LATENCY - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported 16-bit memory between instruction fetch and data ports,
// emulating a fixed access latency with a req/done handshake per port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic [15:0]           o_if_rdata,
  output logic                  o_if_done,
  input  logic                  i_dm_req,
  input  logic                  i_dm_wr,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [15:0]           i_dm_wdata,
  output logic [15:0]           o_dm_rdata,
  output logic                  o_dm_done,
  output logic                  o_dm_err,
  output logic                  o_mem_en,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_wdata,
  input  logic [15:0]           i_mem_rdata
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_RESP = ST_RESP;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~{{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  arb_port_e             r_grant;
  arb_port_e             r_lastGrant;
  logic                  r_wr;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic [15:0]           r_ifRdata;
  logic [15:0]           r_dmRdata;

  arb_port_e             w_winner;
  logic                  w_anyReq;
  logic                  w_misaligned;
  logic                  w_load;
  logic                  w_busy;
  logic                  w_zero;
  logic                  w_access;

  assign w_anyReq     = i_if_req | i_dm_req;
  assign w_winner     = pickPort(i_if_req, i_dm_req, r_lastGrant);
  assign w_misaligned = (w_winner == PORT_DATA) && i_dm_addr[0];
  assign w_load       = (r_state == S_IDLE) && w_anyReq && !w_misaligned;
  assign w_busy       = (r_state == S_BUSY);
  assign w_access     = w_busy && w_zero;

  mem_lat_counter #(
    .LATENCY (LATENCY)
  ) u_latCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dec  (w_busy),
    .o_zero (w_zero)
  );

  // Requests are only looked at in IDLE; everything after the grant uses the latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= PORT_FETCH;
      r_lastGrant <= PORT_FETCH;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_grant <= w_winner;
            if (w_winner == PORT_DATA) begin
              r_wr    <= i_dm_wr;
              r_err   <= i_dm_addr[0];
              r_addr  <= i_dm_addr & ALIGN_MASK;
              r_wdata <= i_dm_wdata;
              r_state <= i_dm_addr[0] ? S_RESP : S_BUSY;
            end else begin
              r_wr    <= 1'b0;
              r_err   <= 1'b0;
              r_addr  <= i_if_addr & ALIGN_MASK;
              r_wdata <= '0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (w_zero) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_lastGrant <= r_grant;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data is captured on the access edge and held until that port's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifRdata <= '0;
      r_dmRdata <= '0;
    end else if (w_access && !r_wr) begin
      if (r_grant == PORT_FETCH) begin
        r_ifRdata <= i_mem_rdata;
      end else begin
        r_dmRdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_en    = w_access;
  assign o_mem_wr    = w_access && r_wr;
  assign o_mem_addr  = w_access ? r_addr  : '0;
  assign o_mem_wdata = w_access ? r_wdata : '0;

  assign o_if_done   = (r_state == S_RESP) && (r_grant == PORT_FETCH);
  assign o_dm_done   = (r_state == S_RESP) && (r_grant == PORT_DATA);
  assign o_dm_err    = o_dm_done && r_err;
  assign o_if_rdata  = r_ifRdata;
  assign o_dm_rdata  = r_dmRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level arbiter model.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int LAT = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [15:0]   if_rdata;
  logic          if_done;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [15:0]   dm_wdata;
  logic [15:0]   dm_rdata;
  logic          dm_done;
  logic          dm_err;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  logic [15:0]   envMem [0:32767];
  logic [15:0]   refMem [0:32767];

  int            tests;
  int            fails;
  int            lastGrant;
  logic [15:0]   expIfData;
  logic [15:0]   expDmData;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_rdata  (if_rdata),
    .o_if_done   (if_done),
    .i_dm_req    (dm_req),
    .i_dm_wr     (dm_wr),
    .i_dm_addr   (dm_addr),
    .i_dm_wdata  (dm_wdata),
    .o_dm_rdata  (dm_rdata),
    .o_dm_done   (dm_done),
    .o_dm_err    (dm_err),
    .o_mem_en    (mem_en),
    .o_mem_wr    (mem_wr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The memory instance the arbiter drives: combinational read, write on the clock edge.
  assign mem_rdata = envMem[mem_addr[AW-1:1]];
  always @(posedge clk) begin
    if (mem_en && mem_wr) envMem[mem_addr[AW-1:1]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({if_done, dm_done, dm_err, mem_en, mem_wr, mem_addr, mem_wdata}), 64'd0);
    checkOutput({tag, "_rdata"}, 64'({if_rdata, dm_rdata}), 64'd0);
  endtask

  // One round: requests raised together in an IDLE cycle (k=0), each held until its done.
  task automatic applyStimulus(input bit doIf, input bit doDm, input bit dmWr,
                               input logic [15:0] ifAddr, input logic [15:0] dmAddr,
                               input logic [15:0] dmWdata, input bit scramble);
    int          nOps;
    int          port [2];
    int          acc [2];
    logic [15:0] accAddr [2];
    logic [15:0] accWdata [2];
    bit          accWr [2];
    int          t;
    int          expIfDoneK;
    int          expDmDoneK;
    int          expErrCnt;
    int          expMemEn;
    int          lastK;
    int          ifDoneCnt;
    int          dmDoneCnt;
    int          errCnt;
    int          memEnCnt;
    int          ifDoneK;
    int          dmDoneK;
    int          hit;
    logic [15:0] ifSeen;
    logic [15:0] dmSeen;
    bit          dropIf;
    bit          dropDm;

    nOps = 0; t = 0; expIfDoneK = -1; expDmDoneK = -1; expErrCnt = 0; expMemEn = 0;
    ifDoneCnt = 0; dmDoneCnt = 0; errCnt = 0; memEnCnt = 0; ifDoneK = -1; dmDoneK = -1;
    ifSeen = '0; dmSeen = '0;
    port[0] = 0; port[1] = 0; acc[0] = -1; acc[1] = -1;
    accAddr[0] = '0; accAddr[1] = '0; accWdata[0] = '0; accWdata[1] = '0; accWr[0] = 0; accWr[1] = 0;

    if (doIf && doDm) begin
      port[0] = (lastGrant == 0) ? 1 : 0;
      port[1] = 1 - port[0];
      nOps = 2;
    end else if (doIf) begin
      port[0] = 0; nOps = 1;
    end else if (doDm) begin
      port[0] = 1; nOps = 1;
    end

    for (int i = 0; i < nOps; i++) begin
      if (port[i] == 0) begin
        acc[i] = t + LAT; accAddr[i] = {ifAddr[15:1], 1'b0}; accWr[i] = 0;
        expIfDoneK = t + LAT + 1;
        expIfData = refMem[ifAddr[15:1]];
        expMemEn++;
        t += LAT + 2;
      end else if (dmAddr[0]) begin
        expDmDoneK = t + 1;
        expErrCnt = 1;
        t += 2;
      end else begin
        acc[i] = t + LAT; accAddr[i] = dmAddr; accWr[i] = dmWr; accWdata[i] = dmWdata;
        expDmDoneK = t + LAT + 1;
        if (dmWr) refMem[dmAddr[15:1]] = dmWdata;
        else expDmData = refMem[dmAddr[15:1]];
        expMemEn++;
        t += LAT + 2;
      end
      lastGrant = port[i];
    end
    lastK = t + 2;

    if_req = doIf; if_addr = ifAddr;
    dm_req = doDm; dm_wr = dmWr; dm_addr = dmAddr; dm_wdata = dmWdata;

    for (int k = 0; k <= lastK; k++) begin
      @(negedge clk);
      dropIf = 0; dropDm = 0;
      if (mem_en) begin
        memEnCnt++;
        hit = -1;
        for (int i = 0; i < nOps; i++) if (acc[i] == k) hit = i;
        if (hit < 0) begin
          checkOutput("memEnCycle", 64'(k), 64'(acc[0]));
        end else begin
          checkOutput("memWr", 64'(mem_wr), 64'(accWr[hit]));
          checkOutput("memAddr", 64'(mem_addr), 64'(accAddr[hit]));
          if (accWr[hit]) checkOutput("memWdata", 64'(mem_wdata), 64'(accWdata[hit]));
        end
      end else begin
        checkOutput("memIdleZero", 64'({mem_wr, mem_addr, mem_wdata}), 64'd0);
      end
      if (if_done) begin ifDoneCnt++; ifDoneK = k; ifSeen = if_rdata; dropIf = 1; end
      if (dm_done) begin dmDoneCnt++; dmDoneK = k; dmSeen = dm_rdata; dropDm = 1; end
      if (dm_err) errCnt++;
      @(posedge clk); #1;
      if (k == 0 && scramble) begin
        if (port[0] == 0) begin
          if_addr = 16'($urandom);
        end else begin
          dm_addr = 16'($urandom); dm_wdata = 16'($urandom); dm_wr = 1'($urandom);
        end
      end
      if (dropIf) if_req = 0;
      if (dropDm) dm_req = 0;
    end

    checkOutput("ifDoneCnt", 64'(ifDoneCnt), doIf ? 64'd1 : 64'd0);
    checkOutput("dmDoneCnt", 64'(dmDoneCnt), doDm ? 64'd1 : 64'd0);
    if (doIf) begin
      checkOutput("ifDoneCycle", 64'(ifDoneK), 64'(expIfDoneK));
      checkOutput("ifRdata", 64'(ifSeen), 64'(expIfData));
    end
    if (doDm) begin
      checkOutput("dmDoneCycle", 64'(dmDoneK), 64'(expDmDoneK));
      checkOutput("dmRdata", 64'(dmSeen), 64'(expDmData));
    end
    checkOutput("dmErrCnt", 64'(errCnt), 64'(expErrCnt));
    checkOutput("memEnCnt", 64'(memEnCnt), 64'(expMemEn));
    checkOutput("ifRdataHeld", 64'(if_rdata), 64'(expIfData));
    checkOutput("dmRdataHeld", 64'(dm_rdata), 64'(expDmData));
    if_req = 0; dm_req = 0;
  endtask

  initial begin
    int          mode;
    logic [15:0] ra;
    logic [15:0] rb;
    int          memEnSeen;
    int          doneSeen;

    tests = 0; fails = 0; lastGrant = 0;
    expIfData = '0; expDmData = '0;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 32768; i++) begin
      envMem[i] = 16'(i * 16'h0101 + 16'h5A);
      refMem[i] = 16'(i * 16'h0101 + 16'h5A);
    end
    envMem[16'h0010 >> 1] = 16'hBEEF;
    refMem[16'h0010 >> 1] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1 checkAllZero("resetState");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] tie after reset: data port first");
    applyStimulus(1, 1, 0, 16'h0010, 16'h0030, 16'h0000, 0);
    $display("[TB] fetch read of 0xBEEF, odd fetch address ignored in bit 0");
    applyStimulus(1, 0, 0, 16'h0011, 16'h0000, 16'h0000, 0);
    $display("[TB] data write then read with inputs scrambled during BUSY");
    applyStimulus(0, 1, 1, 16'h0000, 16'h0020, 16'h1234, 1);
    applyStimulus(0, 1, 0, 16'h0000, 16'h0020, 16'h0000, 1);
    $display("[TB] misaligned data request");
    applyStimulus(0, 1, 0, 16'h0000, 16'h0021, 16'h0000, 0);
    applyStimulus(1, 1, 1, 16'h0020, 16'h0021, 16'hDEAD, 0);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 40; r++) begin
      mode = int'($urandom_range(1, 3));
      ra = 16'($urandom_range(0, 127));
      rb = 16'($urandom_range(0, 63)) << 1;
      if ($urandom_range(0, 5) == 0) rb[0] = 1'b1;
      applyStimulus(mode[0], mode[1], 1'($urandom), ra, rb, 16'($urandom), 1'($urandom));
    end

    $display("[TB] reset in the middle of a write");
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0040; dm_wdata = 16'hA5A5;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midReset");
    memEnSeen = 0; doneSeen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_en) memEnSeen++;
      if (dm_done || if_done) doneSeen++;
    end
    dm_req = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midResetMemEn", 64'(memEnSeen), 64'd0);
    checkOutput("midResetDone", 64'(doneSeen), 64'd0);
    checkOutput("midResetMemKept", 64'(envMem[16'h0040 >> 1]), 64'(refMem[16'h0040 >> 1]));
    checkAllZero("afterMidReset");
    lastGrant = 0; expIfData = '0; expDmData = '0;

    applyStimulus(1, 1, 0, 16'h0040, 16'h0010, 16'h0000, 0);
    applyStimulus(1, 1, 0, 16'h0020, 16'h0040, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
